// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB pipeline stage.
//   XLEN    : default datapath width of the writeback operands
//   REG_AW  : default register-file address width
//   CNT_W   : default width of the load-stall counter
//   state_e : stage state, IDLE (ready for a new instruction) or
//             WAIT (a load is outstanding at the data memory)
package mem_wb_stage_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/mem_wb_stage_sat_counter.sv
// Saturating up-counter.
//   clk     : rising-edge clock
//   reset   : asynchronous active-high reset, clears the count
//   clear_i : synchronous clear, takes priority over inc_i
//   inc_i   : add one this cycle unless already at all-ones
//   count_o : registered count value
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, then increment while not saturated.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = {W{1'b0}};
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: registers the writeback operands (ALU result on
// wb_a, load data on wb_b), the select bit and the destination register,
// and holds off the MEM stage while a load waits for its read data.
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid/in_ready   : MEM-stage handshake (in_ready only in IDLE)
//   in_alu_result, in_rd, in_reg_write, in_mem_to_reg : incoming instruction
//   flush               : kills the incoming or outstanding instruction
//   dmem_rvalid/rdata   : data-memory read response
//   wb_valid            : one-cycle pulse, writeback operands are valid
//   wb_a, wb_b, wb_sel  : writeback select operands and select
//   wb_rd, wb_we        : register-file destination and write enable
//   stall_cnt           : saturating count of cycles spent waiting for loads
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN   = mem_wb_stage_pkg::XLEN,
  parameter int REG_AW = mem_wb_stage_pkg::REG_AW,
  parameter int CNT_W  = mem_wb_stage_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic              flush,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_a,
  output logic [XLEN-1:0]   wb_b,
  output logic              wb_sel,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_we,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e            state_q, state_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_we_q, wb_we_d;
  logic [XLEN-1:0]   wb_a_q, wb_a_d;
  logic [XLEN-1:0]   wb_b_q, wb_b_d;
  logic              wb_sel_q, wb_sel_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic              reg_write_q, reg_write_d;
  logic              accept_s;
  logic              stall_inc_s;

  assign in_ready = (state_q == IDLE);
  assign accept_s = in_valid & in_ready & ~flush;

  // Next state and next writeback operands.
  always_comb begin
    state_d     = state_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = 1'b0;
    wb_a_d      = wb_a_q;
    wb_b_d      = wb_b_q;
    wb_sel_d    = wb_sel_q;
    wb_rd_d     = wb_rd_q;
    reg_write_d = reg_write_q;
    stall_inc_s = 1'b0;
    case (state_q)
      IDLE: begin
        // A response arriving here belongs to nothing and is ignored.
        if (accept_s) begin
          wb_a_d      = in_alu_result;
          wb_rd_d     = in_rd;
          reg_write_d = in_reg_write;
          wb_sel_d    = in_mem_to_reg;
          if (in_mem_to_reg) begin
            state_d = WAIT;
          end else begin
            wb_valid_d = 1'b1;
            wb_we_d    = in_reg_write & (in_rd != {REG_AW{1'b0}});
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (flush) begin
          // Drops the load, including any response in this same cycle.
          state_d     = IDLE;
          stall_inc_s = 1'b1;
        end else if (dmem_rvalid) begin
          wb_b_d     = dmem_rdata;
          wb_valid_d = 1'b1;
          wb_we_d    = reg_write_q & (wb_rd_q != {REG_AW{1'b0}});
          state_d    = IDLE;
        end else begin
          stall_inc_s = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stage registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_a_q      <= {XLEN{1'b0}};
      wb_b_q      <= {XLEN{1'b0}};
      wb_sel_q    <= 1'b0;
      wb_rd_q     <= {REG_AW{1'b0}};
      reg_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_a_q      <= wb_a_d;
      wb_b_q      <= wb_b_d;
      wb_sel_q    <= wb_sel_d;
      wb_rd_q     <= wb_rd_d;
      reg_write_q <= reg_write_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear_i (1'b0),
    .inc_i   (stall_inc_s),
    .count_o (stall_cnt)
  );

  assign wb_valid = wb_valid_q;
  assign wb_we    = wb_we_q;
  assign wb_a     = wb_a_q;
  assign wb_b     = wb_b_q;
  assign wb_sel   = wb_sel_q;
  assign wb_rd    = wb_rd_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_alu_result;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_mem_to_reg;
  logic        flush;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;
  logic        wb_valid;
  logic [63:0] wb_a;
  logic [63:0] wb_b;
  logic        wb_sel;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] stall_cnt;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        sel;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [63:0] LOAD_DATA = 64'hDEADBEEF_CAFEF00D;

  mem_wb_stage dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_alu_result (in_alu_result),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .in_mem_to_reg (in_mem_to_reg),
    .flush         (flush),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_a          (wb_a),
    .wb_b          (wb_b),
    .wb_sel        (wb_sel),
    .wb_rd         (wb_rd),
    .wb_we         (wb_we),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every writeback pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && wb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb: wb_valid=1 rd=%0d with no expected writeback", wb_rd);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_a", wb_a, e.a);
        chk("wb_b", wb_b, e.b);
        chk("wb_sel", {63'd0, wb_sel}, {63'd0, e.sel});
        chk("wb_rd", {59'd0, wb_rd}, {59'd0, e.rd});
        chk("wb_we", {63'd0, wb_we}, {63'd0, e.we});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_mem_to_reg = 1'b0;
    in_reg_write  = 1'b0;
    flush         = 1'b0;
    dmem_rvalid   = 1'b0;
  endtask

  task automatic issue(input logic [63:0] alu, input logic [4:0] rd,
                       input logic rw, input logic load);
    in_valid      = 1'b1;
    in_alu_result = alu;
    in_rd         = rd;
    in_reg_write  = rw;
    in_mem_to_reg = load;
  endtask

  task automatic expect_wb(input logic [63:0] a, input logic [63:0] b,
                           input logic sel, input logic [4:0] rd, input logic we);
    exp_t e;
    e.a = a; e.b = b; e.sel = sel; e.rd = rd; e.we = we;
    exp_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb_valid"}, {63'd0, wb_valid}, 64'd0);
    chk({tag, "_wb_a"}, wb_a, 64'd0);
    chk({tag, "_wb_b"}, wb_b, 64'd0);
    chk({tag, "_wb_sel_rd_we"}, {57'd0, wb_sel, wb_rd, wb_we}, 64'd0);
    chk({tag, "_stall_cnt"}, {32'd0, stall_cnt}, 64'd0);
  endtask

  initial begin
    reset         = 1'b1;
    in_alu_result = 64'd0;
    in_rd         = 5'd0;
    dmem_rdata    = 64'd0;
    idle_inputs();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("ready_after_reset", {63'd0, in_ready}, 64'd1);

    // ALU op, rd=5
    issue(64'h1234, 5'd5, 1'b1, 1'b0);
    expect_wb(64'h1234, 64'd0, 1'b0, 5'd5, 1'b1);
    step();
    idle_inputs();
    chk("alu_ready", {63'd0, in_ready}, 64'd1);
    chk("alu_valid", {63'd0, wb_valid}, 64'd1);
    step();
    chk("alu_pulse_ends", {63'd0, wb_valid}, 64'd0);

    // Load rd=7, three empty wait cycles then the response
    issue(64'h55, 5'd7, 1'b1, 1'b1);
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      chk("load_wait_ready", {63'd0, in_ready}, 64'd0);
      chk("load_wait_valid", {63'd0, wb_valid}, 64'd0);
      step();
    end
    chk("load_resp_ready", {63'd0, in_ready}, 64'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = LOAD_DATA;
    expect_wb(64'h55, LOAD_DATA, 1'b1, 5'd7, 1'b1);
    step();
    idle_inputs();
    chk("load_done_ready", {63'd0, in_ready}, 64'd1);
    chk("load_stall_cnt", {32'd0, stall_cnt}, 64'd3);
    step();

    // Flush in WAIT with a coincident response
    issue(64'h77, 5'd9, 1'b1, 1'b1);
    step();
    idle_inputs();
    flush       = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'h0BAD_0BAD_0BAD_0BAD;
    step();
    idle_inputs();
    chk("flush_wait_valid", {63'd0, wb_valid}, 64'd0);
    chk("flush_wait_ready", {63'd0, in_ready}, 64'd1);
    chk("flush_wait_wb_b", wb_b, LOAD_DATA);

    // Back-to-back ALU ops on x0 then x3
    issue(64'hA, 5'd0, 1'b1, 1'b0);
    expect_wb(64'hA, LOAD_DATA, 1'b0, 5'd0, 1'b0);
    step();
    issue(64'hB, 5'd3, 1'b1, 1'b0);
    expect_wb(64'hB, LOAD_DATA, 1'b0, 5'd3, 1'b1);
    step();
    idle_inputs();
    chk("b2b_second_valid", {63'd0, wb_valid}, 64'd1);
    step();
    chk("b2b_end_valid", {63'd0, wb_valid}, 64'd0);

    // Spurious response in IDLE
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'h1111_2222_3333_4444;
    step();
    idle_inputs();
    chk("spurious_valid", {63'd0, wb_valid}, 64'd0);
    chk("spurious_wb_b", wb_b, LOAD_DATA);
    chk("spurious_ready", {63'd0, in_ready}, 64'd1);

    // Flush in IDLE blocks acceptance
    issue(64'hC, 5'd4, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    idle_inputs();
    chk("flush_idle_valid", {63'd0, wb_valid}, 64'd0);
    chk("flush_idle_wb_a", wb_a, 64'hB);

    // Asynchronous reset while a load is outstanding
    issue(64'hE, 5'd6, 1'b1, 1'b1);
    step();
    idle_inputs();
    step();
    chk("pre_reset_ready", {63'd0, in_ready}, 64'd0);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    #3;
    reset = 1'b0;
    step();
    chk("post_reset_ready", {63'd0, in_ready}, 64'd1);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'h9999;
    step();
    idle_inputs();
    chk("post_reset_dropped", {63'd0, wb_valid}, 64'd0);

    // ALU op after reset sees cleared wb_b
    issue(64'hF00D, 5'd31, 1'b1, 1'b0);
    expect_wb(64'hF00D, 64'd0, 1'b0, 5'd31, 1'b1);
    step();
    idle_inputs();
    step();
    step();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline stage; the driving end of the writeback 2:1 select.
- Registers the ALU result (writeback operand a), the load data (operand b), the select bit and the destination register.
- Waits for multi-cycle data-memory read responses and backpressures the MEM stage while a load is outstanding.
- Sits between the data-memory interface and the register-file write port.

Parameters:
XLEN, 64, datapath width of the writeback operands
REG_AW, 5, register-file address width
CNT_W, 32, width of the saturating load-stall counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  MEM stage presents an instruction
in_ready  output  1  stage accepts the instruction this cycle
in_alu_result  input  XLEN  ALU result / address-independent writeback value
in_rd  input  REG_AW  destination register
in_reg_write  input  1  instruction writes the register file
in_mem_to_reg  input  1  1 = load (writeback from memory), 0 = ALU
flush  input  1  kill the in-flight/incoming instruction
dmem_rvalid  input  1  data-memory read data valid
dmem_rdata  input  XLEN  data-memory read data
wb_valid  output  1  writeback operands valid, one-cycle pulse
wb_a  output  XLEN  ALU operand to the writeback select
wb_b  output  XLEN  load-data operand to the writeback select
wb_sel  output  1  0 selects wb_a, 1 selects wb_b
wb_rd  output  REG_AW  destination register
wb_we  output  1  register-file write enable
stall_cnt  output  CNT_W  total cycles spent waiting for load data

Behaviour:
- Reset:
  - State is IDLE.
  - wb_valid, wb_a, wb_b, wb_sel, wb_rd, wb_we and stall_cnt are all 0.
  - in_ready is 1 once reset is released.
- in_ready = (state == IDLE). It is combinational from state only.
- Acceptance: in_valid & in_ready & !flush at a rising edge.
- IDLE, accepting an ALU op (in_mem_to_reg = 0):
  - Next cycle: wb_a = in_alu_result, wb_sel = 0, wb_rd = in_rd, wb_valid = 1.
  - wb_b is unchanged. State stays IDLE.
  - Latency 1; back-to-back throughput 1 per cycle.
- IDLE, accepting a load (in_mem_to_reg = 1):
  - Capture wb_a = in_alu_result, wb_rd, the reg_write bit and wb_sel = 1.
  - Go to WAIT. wb_valid = 0 next cycle.
- WAIT:
  - in_ready = 0; stall_cnt increments by 1 each cycle.
  - On dmem_rvalid & !flush: wb_b = dmem_rdata, wb_valid = 1 next cycle, return to IDLE.
  - Load latency is 1 cycle after dmem_rvalid.
- wb_we = wb_valid & captured reg_write & (wb_rd != 0). It is registered together with wb_valid; x0 is never written.
- wb_valid is a single-cycle pulse. It deasserts the cycle after, unless a new ALU op is accepted.
- flush:
  - In IDLE: the incoming instruction is not accepted; wb_valid = 0 next cycle.
  - In WAIT: return to IDLE. A dmem_rvalid in the same cycle is discarded; wb_valid stays 0.
  - A flush does not disturb an already-issued wb_valid pulse.
- dmem_rvalid while in IDLE is ignored; no state or output change.
- stall_cnt:
  - Saturates at all-ones.
  - Cleared only by reset.
  - Does not increment in the cycle in which dmem_rvalid is accepted.
- Reset mid-WAIT: immediate return to IDLE; all outputs cleared asynchronously; the pending load is dropped.
- wb_a, wb_b, wb_rd and wb_sel hold their last values while wb_valid = 0.

Decomposition:
- Shared package (pipeline pkg): XLEN and REG_AW constants, and a 2-value state enum (IDLE, WAIT).
- Sub-module: sat_counter (parameter W, inputs inc/clear, saturating), used for stall_cnt.
- Everything else stays flat in mem_wb_stage.

Test Plan:
- Reset then ALU op: alu=0x1234, rd=5, reg_write=1 → next cycle wb_valid=1, wb_a=0x1234, wb_sel=0, wb_we=1, wb_rd=5; in_ready stays 1.
- Load: accept with rd=7, then 3 idle cycles, then dmem_rvalid with rdata=0xDEADBEEF_CAFEF00D.
  - in_ready = 0 for 4 cycles.
  - Next cycle: wb_valid=1, wb_sel=1, wb_b=0xDEADBEEF_CAFEF00D, wb_we=1.
  - stall_cnt = 3.
- Flush in WAIT with a coincident dmem_rvalid → wb_valid stays 0, state IDLE, in_ready=1 next cycle.
- Back-to-back ALU ops on rd=0 and rd=3 → two consecutive wb_valid pulses; wb_we=0 then 1.
- Spurious dmem_rvalid in IDLE → no wb_valid; wb_b unchanged.
- Assert reset asynchronously during WAIT → outputs 0 immediately; in_ready=1 after reset release.
